// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so that a counter is always at least one bit wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_mul_twos_negate.sv
// Combinational conditional two's-complement negate.
module twos_negate #(
  parameter int unsigned N = 4
) (
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  // Pass through, or invert-and-increment when enabled.
  always_comb begin
    y = en ? (~x + N'(1)) : x;
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial product per clock, optional signed mode.
module seq_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_e          state_q, state_d;
  logic            neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   result_q, result_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_fixed;
  logic             last_iter;

  // Operand magnitudes; the most negative value maps to 2^(W-1), which still fits unsigned.
  twos_negate #(.N(WIDTH)) u_abs_a (
    .en (signed_mode & a[WIDTH-1]),
    .x  (a),
    .y  (a_mag)
  );

  twos_negate #(.N(WIDTH)) u_abs_b (
    .en (signed_mode & b[WIDTH-1]),
    .x  (b),
    .y  (b_mag)
  );

  // Final sign fix of the unsigned magnitude product; zero negates to zero.
  twos_negate #(.N(PW)) u_sign_fix (
    .en (neg_q),
    .x  (acc_q),
    .y  (acc_fixed)
  );

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, WIDTH iterations in RUN, one FIX cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next values.
  always_comb begin
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIX: begin
        result_d = acc_fixed;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, aborting any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
